instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 128 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Sequential instruction fetcher for a fixed two-cycle program memory: tracks in-flight
// reads, buffers returned words for the decoder and flushes cleanly on branch redirects.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [31:0] mem_addr,
  output logic        mem_read_request,
  input  logic [31:0] mem_instr,
  input  logic        mem_data_valid,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  input  logic        ready_in
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   fetch_pc;
  logic          s1_live;
  logic          s2_live;
  logic [31:0]   s1_pc;
  logic [31:0]   s2_pc;
  logic [31:0]   buf_instr [FIFO_DEPTH];
  logic [31:0]   buf_pc    [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] pending;
  logic          issue;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_target;

  assign mem_addr  = fetch_pc;
  assign valid_out = (count != (AW+1)'(0));
  assign instr_out = buf_instr[rd_ptr];
  assign pc_out    = buf_pc[rd_ptr];

  // Next state, issue credit and buffer push/pop decisions.
  always_comb begin
    state_next      = RUN;
    issue           = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    pending         = CW'(count) + CW'(mem_read_request) + CW'(s1_live) + CW'(s2_live);
    redirect_target = redirect_pc_in & 32'hFFFF_FFFC;
    case (state)
      RUN:     state_next = redirect_in ? FLUSH : RUN;
      FLUSH:   state_next = redirect_in ? FLUSH : RUN;
      default: state_next = RUN;
    endcase
    if (redirect_in) begin
      issue = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
    end else begin
      // Every buffered, presented or tracked read may still land in the buffer.
      issue = (pending < CW'(FIFO_DEPTH));
      push  = mem_data_valid & s2_live & (state == RUN);
      pop   = valid_out & ready_in;
    end
  end

  // Fetch address, request strobe, in-flight tracker and buffer occupancy.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= RUN;
      fetch_pc         <= RESET_PC;
      mem_read_request <= 1'b0;
      s1_live          <= 1'b0;
      s2_live          <= 1'b0;
      s1_pc            <= 32'h0000_0000;
      s2_pc            <= 32'h0000_0000;
      count            <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
    end else begin
      state <= state_next;
      s1_pc <= fetch_pc;
      s2_pc <= s1_pc;
      if (redirect_in) begin
        // The read presented during the redirect cycle is never tracked; the
        // target is presented straight away in the flush cycle.
        fetch_pc         <= redirect_target;
        mem_read_request <= 1'b1;
        s1_live          <= 1'b0;
        s2_live          <= 1'b0;
        count            <= '0;
        wr_ptr           <= '0;
        rd_ptr           <= '0;
      end else begin
        fetch_pc         <= mem_read_request ? fetch_pc + 32'd4 : fetch_pc;
        mem_read_request <= issue;
        s1_live          <= mem_read_request;
        s2_live          <= s1_live;
        count            <= count + (AW+1)'(push) - (AW+1)'(pop);
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end

  // Buffer storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_instr[i] <= 32'h0000_0000;
        buf_pc[i]    <= 32'h0000_0000;
      end
    end else if (push) begin
      buf_instr[wr_ptr] <= mem_instr;
      buf_pc[wr_ptr]    <= s2_pc;
    end
  end
endmodule
